// File: rtl/tetris_pkg.sv
// Shared playfield constants and the row-clear engine state type.
package tetris_pkg;

  localparam int ROWS   = 20;
  localparam int COLS   = 10;
  localparam int ROW_AW = 5;

  localparam logic [COLS-1:0] FULL_ROW = {COLS{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    SCAN_RD,
    SCAN_CHK,
    SHIFT_RD,
    SHIFT_WR,
    TOP_CLR,
    FINISH
  } state_t;

endpackage

// File: rtl/vram_port_mux.sv
// Steers port A of the playfield RAM to either the CPU or the row-clear engine.
module vram_port_mux #(
  parameter int COLS = 10,
  parameter int AW   = 5
) (
  input  logic            grant,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [COLS-1:0] cpu_wdata,
  input  logic            cpu_wren,
  input  logic            cpu_rden,
  input  logic [AW-1:0]   eng_addr,
  input  logic [COLS-1:0] eng_wdata,
  input  logic            eng_wren,
  input  logic            eng_rden,
  output logic [AW-1:0]   ram_addr,
  output logic [COLS-1:0] ram_wdata,
  output logic            ram_wren,
  output logic            ram_rden
);

  // grant high hands the whole port to the engine; the CPU side is fully blocked
  always_comb begin
    if (grant) begin
      ram_addr  = eng_addr;
      ram_wdata = eng_wdata;
      ram_wren  = eng_wren;
      ram_rden  = eng_rden;
    end else begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_wren  = cpu_wren;
      ram_rden  = cpu_rden;
    end
  end

endmodule

// File: rtl/row_clear_ctrl.sv
// Scans the playfield bottom-up, collapses full rows and shares RAM port A with the CPU.
module row_clear_ctrl #(
  parameter int ROWS = tetris_pkg::ROWS,
  parameter int COLS = tetris_pkg::COLS
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          START,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [4:0]                    LINES,
  input  logic [tetris_pkg::ROW_AW-1:0] CPU_ADDR,
  input  logic                          CPU_RD,
  input  logic                          CPU_WR,
  input  logic [COLS-1:0]               CPU_WDATA,
  output logic                          CPU_WAIT,
  output logic [COLS-1:0]               CPU_RDATA,
  output logic                          CPU_RVALID,
  output logic [tetris_pkg::ROW_AW-1:0] RAM_ADDR,
  output logic [COLS-1:0]               RAM_WDATA,
  output logic                          RAM_WREN,
  output logic                          RAM_RDEN,
  input  logic [COLS-1:0]               RAM_Q
);

  import tetris_pkg::*;

  localparam logic [COLS-1:0] FULL_MASK = {COLS{1'b1}};

  state_t            state;
  logic [ROW_AW-1:0] scan_row;
  logic [ROW_AW-1:0] dst_row;
  logic [4:0]        lines_q;
  logic              start_pending;
  logic              busy_q;
  logic              done_q;
  logic              rvalid_q;

  logic              idle;
  logic              cpu_req;
  logic              cpu_wren;
  logic              cpu_rden;
  logic [ROW_AW-1:0] eng_addr;
  logic [COLS-1:0]   eng_wdata;
  logic              eng_wren;
  logic              eng_rden;

  assign idle    = (state == IDLE);
  assign cpu_req = CPU_RD | CPU_WR;

  // A write wins over a simultaneous read so only one strobe ever reaches the RAM
  assign cpu_wren = CPU_WR & RESET_N;
  assign cpu_rden = CPU_RD & ~CPU_WR & RESET_N;

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign LINES      = lines_q;
  assign CPU_WAIT   = ~idle & cpu_req;
  assign CPU_RVALID = rvalid_q;
  assign CPU_RDATA  = RAM_Q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state         <= IDLE;
      scan_row      <= '0;
      dst_row       <= '0;
      lines_q       <= '0;
      start_pending <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rvalid_q      <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          rvalid_q <= CPU_RD & ~CPU_WR;
          if (cpu_req) begin
            if (START) start_pending <= 1'b1;
          end else if (START || start_pending) begin
            start_pending <= 1'b0;
            scan_row      <= ROW_AW'(ROWS - 1);
            lines_q       <= '0;
            busy_q        <= 1'b1;
            state         <= SCAN_RD;
          end
        end
        SCAN_RD: state <= SCAN_CHK;
        SCAN_CHK: begin
          if (RAM_Q == FULL_MASK) begin
            dst_row <= scan_row;
            state   <= (scan_row == '0) ? TOP_CLR : SHIFT_RD;
          end else if (scan_row == '0) begin
            done_q <= 1'b1;
            state  <= FINISH;
          end else begin
            scan_row <= scan_row - 1'b1;
            state    <= SCAN_RD;
          end
        end
        SHIFT_RD: state <= SHIFT_WR;
        SHIFT_WR: begin
          dst_row <= dst_row - 1'b1;
          state   <= (dst_row == ROW_AW'(1)) ? TOP_CLR : SHIFT_RD;
        end
        TOP_CLR: begin
          if (lines_q != 5'(ROWS)) lines_q <= lines_q + 1'b1;
          state <= SCAN_RD;
        end
        FINISH: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Engine port drive decoded from the registered state; RESET_N gates strobes so an abort never writes
  always_comb begin
    eng_addr  = '0;
    eng_wdata = '0;
    eng_wren  = 1'b0;
    eng_rden  = 1'b0;
    case (state)
      SCAN_RD: begin
        eng_rden = RESET_N;
        eng_addr = scan_row;
      end
      SHIFT_RD: begin
        eng_rden = RESET_N;
        eng_addr = (dst_row != '0) ? dst_row - 1'b1 : '0;
      end
      SHIFT_WR: begin
        eng_wren  = RESET_N;
        eng_addr  = dst_row;
        eng_wdata = RAM_Q;
      end
      TOP_CLR: begin
        eng_wren = RESET_N;
      end
      default: ;
    endcase
  end

  vram_port_mux #(
    .COLS (COLS),
    .AW   (ROW_AW)
  ) u_port_mux (
    .grant     (~idle),
    .cpu_addr  (CPU_ADDR),
    .cpu_wdata (CPU_WDATA),
    .cpu_wren  (cpu_wren),
    .cpu_rden  (cpu_rden),
    .eng_addr  (eng_addr),
    .eng_wdata (eng_wdata),
    .eng_wren  (eng_wren),
    .eng_rden  (eng_rden),
    .ram_addr  (RAM_ADDR),
    .ram_wdata (RAM_WDATA),
    .ram_wren  (RAM_WREN),
    .ram_rden  (RAM_RDEN)
  );

endmodule

// File: tb/tb_row_clear_ctrl.sv
// Self-checking bench for row_clear_ctrl: playfield RAM model plus a row-collapse reference model.
module tb_row_clear_ctrl;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam logic [COLS-1:0] FULL = {COLS{1'b1}};

  logic            CLK;
  logic            RESET_N;
  logic            START;
  logic            BUSY;
  logic            DONE;
  logic [4:0]      LINES;
  logic [4:0]      CPU_ADDR;
  logic            CPU_RD;
  logic            CPU_WR;
  logic [COLS-1:0] CPU_WDATA;
  logic            CPU_WAIT;
  logic [COLS-1:0] CPU_RDATA;
  logic            CPU_RVALID;
  logic [4:0]      RAM_ADDR;
  logic [COLS-1:0] RAM_WDATA;
  logic            RAM_WREN;
  logic            RAM_RDEN;
  logic [COLS-1:0] RAM_Q;

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] board [ROWS];
  logic [COLS-1:0] exp_board [ROWS];
  int exp_lines, exp_cycles, exp_shift, exp_top;

  int n_checks = 0;
  int n_fail = 0;
  int shift_cnt = 0;
  int top_cnt = 0;
  int overlap_cnt = 0;
  int finish_cnt = 0;

  row_clear_ctrl dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .LINES      (LINES),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_RD     (CPU_RD),
    .CPU_WR     (CPU_WR),
    .CPU_WDATA  (CPU_WDATA),
    .CPU_WAIT   (CPU_WAIT),
    .CPU_RDATA  (CPU_RDATA),
    .CPU_RVALID (CPU_RVALID),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_WDATA  (RAM_WDATA),
    .RAM_WREN   (RAM_WREN),
    .RAM_RDEN   (RAM_RDEN),
    .RAM_Q      (RAM_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Playfield RAM port A with one cycle of read latency
  always @(posedge CLK) begin
    if (RAM_WREN && RAM_ADDR < 5'(ROWS)) mem[RAM_ADDR] <= RAM_WDATA;
    if (RAM_RDEN) RAM_Q <= (RAM_ADDR < 5'(ROWS)) ? mem[RAM_ADDR] : '0;
  end

  // Classify engine writes and flag illegal port activity
  always @(posedge CLK) begin
    if (BUSY && RAM_WREN && RAM_ADDR != 5'd0) shift_cnt <= shift_cnt + 1;
    if (BUSY && RAM_WREN && RAM_ADDR == 5'd0) top_cnt <= top_cnt + 1;
    if (RAM_WREN && RAM_RDEN) overlap_cnt <= overlap_cnt + 1;
    if (DONE && (RAM_WREN || RAM_RDEN)) finish_cnt <= finish_cnt + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cpuWrite(input logic [4:0] addr, input logic [COLS-1:0] data, output int waited);
    step();
    CPU_ADDR  = addr;
    CPU_WDATA = data;
    CPU_WR    = 1'b1;
    #1;
    waited = 0;
    while (CPU_WAIT && waited < 2000) begin
      step();
      #1;
      waited++;
    end
    if (waited >= 2000) checkOutput("cpu_wr_timeout", 1, 0);
    step();
    CPU_WR = 1'b0;
  endtask

  task automatic cpuRead(input logic [4:0] addr, output logic [COLS-1:0] data);
    step();
    CPU_ADDR = addr;
    CPU_RD   = 1'b1;
    step();
    CPU_RD = 1'b0;
    checkOutput($sformatf("rvalid_row%0d", addr), 32'(CPU_RVALID), 1);
    data = CPU_RDATA;
  endtask

  task automatic loadBoard();
    int w;
    for (int i = 0; i < ROWS; i++) cpuWrite(5'(i), board[i], w);
  endtask

  task automatic checkBoard(input string name);
    logic [COLS-1:0] d;
    for (int i = 0; i < ROWS; i++) begin
      cpuRead(5'(i), d);
      checkOutput($sformatf("%s_row%0d", name, i), 32'(d), 32'(exp_board[i]));
    end
  endtask

  // Full rows vanish, survivors keep their order and sink to the bottom;
  // the k-th full row from the bottom is detected at its index plus k
  task automatic computeModel();
    int k, w, r;
    k = 0;
    w = ROWS - 1;
    exp_cycles = 2 * ROWS + 1;
    exp_shift  = 0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (board[i] == FULL) begin
        r = i + k;
        exp_cycles += 2 * r + 3;
        exp_shift  += r;
        k++;
      end else begin
        exp_board[w] = board[i];
        w--;
      end
    end
    for (int i = w; i >= 0; i--) exp_board[i] = '0;
    exp_lines = (k > ROWS) ? ROWS : k;
    exp_top   = k;
  endtask

  task automatic applyStimulus(input string name);
    int cyc, s0, t0;
    computeModel();
    loadBoard();
    s0 = shift_cnt;
    t0 = top_cnt;
    step();
    START = 1'b1;
    step();
    START = 1'b0;
    cyc = 1;
    checkOutput({name, "_busy_rise"}, 32'(BUSY), 1);
    while (!DONE && cyc < 3000) begin
      step();
      cyc++;
    end
    checkOutput({name, "_done_cycle"}, cyc, exp_cycles);
    checkOutput({name, "_lines"}, 32'(LINES), exp_lines);
    step();
    checkOutput({name, "_busy_fall"}, 32'(BUSY), 0);
    checkOutput({name, "_done_pulse"}, 32'(DONE), 0);
    checkOutput({name, "_shift_writes"}, shift_cnt - s0, exp_shift);
    checkOutput({name, "_top_clears"}, top_cnt - t0, exp_top);
    checkBoard(name);
    checkOutput({name, "_lines_held"}, 32'(LINES), exp_lines);
  endtask

  task automatic clearBoard();
    for (int i = 0; i < ROWS; i++) board[i] = '0;
  endtask

  initial begin
    int waited, cyc, cnt, guard;
    logic [COLS-1:0] d;

    RESET_N   = 1'b0;
    START     = 1'b0;
    CPU_RD    = 1'b0;
    CPU_WR    = 1'b0;
    CPU_ADDR  = '0;
    CPU_WDATA = '0;
    step();
    step();
    checkOutput("reset_outputs", {26'd0, BUSY, DONE, CPU_WAIT, CPU_RVALID, RAM_RDEN, RAM_WREN}, 0);
    checkOutput("reset_lines", 32'(LINES), 0);
    RESET_N = 1'b1;

    clearBoard();
    applyStimulus("empty");

    clearBoard();
    board[19] = FULL;
    board[18] = 10'h155;
    applyStimulus("one_line");

    clearBoard();
    for (int i = 16; i < 20; i++) board[i] = FULL;
    board[15] = 10'h0F0;
    board[14] = 10'h00F;
    applyStimulus("four_lines");

    clearBoard();
    board[0] = FULL;
    applyStimulus("top_row");

    for (int i = 0; i < ROWS; i++) board[i] = FULL;
    applyStimulus("all_full");

    // CPU stalled by a running scan, then START coinciding with a read
    clearBoard();
    computeModel();
    loadBoard();
    step();
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    CPU_ADDR  = 5'd5;
    CPU_WDATA = 10'h2AA;
    CPU_WR    = 1'b1;
    #1;
    checkOutput("cpu_wait_busy", 32'(CPU_WAIT), 1);
    checkOutput("cpu_blocked_wren", 32'(RAM_WREN), 0);
    waited = 0;
    while (CPU_WAIT && waited < 200) begin
      step();
      #1;
      waited++;
    end
    checkOutput("cpu_wait_cycles", waited, 39);
    checkOutput("cpu_wait_release_idle", 32'(BUSY), 0);
    step();
    CPU_WR = 1'b0;
    cpuRead(5'd5, d);
    checkOutput("cpu_wr_landed", 32'(d), 32'h2AA);

    step();
    START    = 1'b1;
    CPU_RD   = 1'b1;
    CPU_ADDR = 5'd5;
    #1;
    checkOutput("start_rd_no_wait", 32'(CPU_WAIT), 0);
    step();
    START  = 1'b0;
    CPU_RD = 1'b0;
    checkOutput("start_rd_rvalid", 32'(CPU_RVALID), 1);
    checkOutput("start_rd_data", 32'(CPU_RDATA), 32'h2AA);
    checkOutput("start_rd_busy_low", 32'(BUSY), 0);
    step();
    checkOutput("start_rd_busy_rise", 32'(BUSY), 1);
    cyc = 0;
    while (!DONE && cyc < 200) begin
      step();
      cyc++;
    end
    checkOutput("start_rd_done_cycle", cyc, 40);
    checkOutput("start_rd_lines", 32'(LINES), 0);
    step();

    // Reset in the middle of the second collapse
    clearBoard();
    board[19] = FULL;
    board[18] = FULL;
    board[17] = 10'h001;
    loadBoard();
    step();
    START = 1'b1;
    step();
    START = 1'b0;
    cnt   = 0;
    guard = 0;
    while (cnt < 21 && guard < 500) begin
      step();
      if (RAM_WREN) cnt++;
      guard++;
    end
    checkOutput("reset_reach_shift_wr", cnt, 21);
    checkOutput("lines_before_reset", 32'(LINES), 1);
    RESET_N = 1'b0;
    #1;
    checkOutput("no_write_in_reset", 32'(RAM_WREN), 0);
    step();
    RESET_N = 1'b1;
    checkOutput("abort_outputs", {26'd0, BUSY, DONE, CPU_WAIT, CPU_RVALID, RAM_RDEN, RAM_WREN}, 0);
    checkOutput("abort_lines", 32'(LINES), 0);
    applyStimulus("after_reset");

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < ROWS; i++)
        board[i] = ($urandom_range(0, 3) == 0) ? FULL : 10'($urandom_range(0, 1022));
      applyStimulus($sformatf("rand%0d", t));
    end

    checkOutput("rd_wr_overlap", overlap_cnt, 0);
    checkOutput("finish_port_idle", finish_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
